// File: rtl/console_uart_if.sv
// Byte-level host side of the console UART: TX write port and RX result port.
interface console_uart_if;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       rx_frame_err;
    logic       rx_parity_err;

    modport master (
        output tx_data, tx_strobe,
        input  tx_ready, rx_data, rx_strobe, rx_frame_err, rx_parity_err
    );

    modport slave (
        input  tx_data, tx_strobe,
        output tx_ready, rx_data, rx_strobe, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/console_uart.sv
// Console UART: FIFO-buffered transmitter and mid-bit-sampling receiver with
// optional parity, sharing one clock but otherwise independent.
module console_uart #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    console_uart_if.slave     bus,
    output logic              tx_pad,
    input  logic              rx_pad
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(DIV / 2 - 1);
    localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]    DATA_MASK  = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3,
        RX_STOP = 3'd4, RX_BREAK = 3'd5
    } rx_state_t;

    // Parity bit that makes the frame odd (PARITY=1) or even (PARITY=2).
    function automatic logic parity_bit(input logic [7:0] d);
        logic [7:0] m;
        m = d & DATA_MASK;
        return (PARITY == 1) ? ~^m : ^m;
    endfunction

    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r, count_next_s;
    logic          tx_ready_r, push_s, pop_s, tx_bit_end_s, fifo_has_s;
    logic [7:0]    head_s;

    tx_state_t     tx_state_r;
    logic [CW-1:0] tx_cnt_r;
    logic [2:0]    tx_idx_r;
    logic [7:0]    tx_shift_r;
    logic          tx_par_r, tx_load_r, tx_pad_r;

    logic          sync1_r, sync2_r;
    rx_state_t     rx_state_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_idx_r;
    logic [7:0]    rx_shift_r, rx_data_r;
    logic          rx_pbit_r, rx_strobe_r, rx_ferr_r, rx_perr_r;

    // FIFO handshake and pop decisions; a pop can only come from IDLE or the last stop bit.
    always_comb begin
        push_s       = bus.tx_strobe & tx_ready_r;
        fifo_has_s   = (count_r != (AW + 1)'(0));
        tx_bit_end_s = (tx_cnt_r == BIT_LAST);
        head_s       = fifo_mem_r[rd_ptr_r];
        case (tx_state_r)
            TX_IDLE: pop_s = ~tx_load_r & fifo_has_s;
            TX_STOP: pop_s = tx_bit_end_s & (tx_idx_r == STOP_LAST) & fifo_has_s;
            default: pop_s = 1'b0;
        endcase
        count_next_s = count_r + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
    end

    // FIFO storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.tx_data & DATA_MASK;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            count_r    <= (AW + 1)'(0);
            tx_ready_r <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r    <= count_next_s;
            tx_ready_r <= (count_next_s != FULL_COUNT);
        end
    end

    // Transmit FSM: IDLE pops the head, then starts the frame on the following edge.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CW'(0);
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_par_r   <= 1'b0;
            tx_load_r  <= 1'b0;
            tx_pad_r   <= 1'b1;
        end else begin
            tx_cnt_r <= tx_bit_end_s ? CW'(0) : tx_cnt_r + CW'(1);
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r <= CW'(0);
                    if (tx_load_r) begin
                        tx_load_r  <= 1'b0;
                        tx_pad_r   <= 1'b0;
                        tx_state_r <= TX_START;
                    end else if (pop_s) begin
                        tx_load_r  <= 1'b1;
                        tx_shift_r <= head_s;
                        tx_par_r   <= parity_bit(head_s);
                    end
                end
                TX_START: if (tx_bit_end_s) begin
                    tx_pad_r   <= tx_shift_r[0];
                    tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                    tx_idx_r   <= 3'd0;
                    tx_state_r <= TX_DATA;
                end
                TX_DATA: if (tx_bit_end_s) begin
                    if (tx_idx_r != DATA_LAST) begin
                        tx_pad_r   <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        tx_idx_r   <= tx_idx_r + 3'd1;
                    end else if (PARITY != 0) begin
                        tx_pad_r   <= tx_par_r;
                        tx_state_r <= TX_PARITY;
                    end else begin
                        tx_pad_r   <= 1'b1;
                        tx_idx_r   <= 3'd0;
                        tx_state_r <= TX_STOP;
                    end
                end
                TX_PARITY: if (tx_bit_end_s) begin
                    tx_pad_r   <= 1'b1;
                    tx_idx_r   <= 3'd0;
                    tx_state_r <= TX_STOP;
                end
                TX_STOP: if (tx_bit_end_s) begin
                    if (tx_idx_r != STOP_LAST) begin
                        tx_idx_r <= tx_idx_r + 3'd1;
                    end else begin
                        // Prefetch here so a queued byte costs only one idle clock.
                        tx_state_r <= TX_IDLE;
                        if (pop_s) begin
                            tx_load_r  <= 1'b1;
                            tx_shift_r <= head_s;
                            tx_par_r   <= parity_bit(head_s);
                        end
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_pad_r   <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input, idling high.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_pad;
            sync2_r <= sync1_r;
        end
    end

    // Receive FSM: centre-samples each bit; a low stop bit parks in BREAK until the line rises.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rx_state_r  <= RX_IDLE;
            rx_cnt_r    <= CW'(0);
            rx_idx_r    <= 3'd0;
            rx_shift_r  <= 8'd0;
            rx_pbit_r   <= 1'b0;
            rx_data_r   <= 8'd0;
            rx_strobe_r <= 1'b0;
            rx_ferr_r   <= 1'b0;
            rx_perr_r   <= 1'b0;
        end else begin
            rx_strobe_r <= 1'b0;
            rx_cnt_r    <= rx_cnt_r + CW'(1);
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= CW'(0);
                    if (!sync2_r) rx_state_r <= RX_START;
                end
                RX_START: if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_r <= CW'(0);
                    if (sync2_r) begin
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_idx_r   <= 3'd0;
                        rx_shift_r <= 8'd0;
                        rx_state_r <= RX_DATA;
                    end
                end
                RX_DATA: if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_r             <= CW'(0);
                    rx_shift_r[rx_idx_r] <= sync2_r;
                    if (rx_idx_r != DATA_LAST) begin
                        rx_idx_r <= rx_idx_r + 3'd1;
                    end else begin
                        rx_state_r <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_r   <= CW'(0);
                    rx_pbit_r  <= sync2_r;
                    rx_state_r <= RX_STOP;
                end
                RX_STOP: if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_r    <= CW'(0);
                    rx_strobe_r <= 1'b1;
                    rx_data_r   <= rx_shift_r;
                    rx_ferr_r   <= ~sync2_r;
                    rx_perr_r   <= (PARITY != 0) && (rx_pbit_r != parity_bit(rx_shift_r));
                    rx_state_r  <= sync2_r ? RX_IDLE : RX_BREAK;
                end
                RX_BREAK: begin
                    rx_cnt_r <= CW'(0);
                    if (sync2_r) rx_state_r <= RX_IDLE;
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    assign tx_pad            = tx_pad_r;
    assign bus.tx_ready      = tx_ready_r;
    assign bus.rx_data       = rx_data_r;
    assign bus.rx_strobe     = rx_strobe_r;
    assign bus.rx_frame_err  = rx_ferr_r;
    assign bus.rx_parity_err = rx_perr_r;
endmodule

// File: tb/tb_console_uart.sv
// Scoreboard bench for console_uart: an 8N1 instance driven/decoded by the bench
// and a 7E2 instance used in loopback and with bench-driven parity errors.
module tb_console_uart;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int DIV    = CLK_HZ / BAUD;

    logic clk = 1'b0;
    logic rst_l;
    logic tx_pad_a, tx_pad_b, rx_pad_a, rx_pad_b, rx_drv_b, loop_b;

    console_uart_if ifa ();
    console_uart_if ifb ();

    console_uart #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) dut_a (
        .clk(clk), .rst_l(rst_l), .bus(ifa), .tx_pad(tx_pad_a), .rx_pad(rx_pad_a)
    );

    console_uart #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_l(rst_l), .bus(ifb), .tx_pad(tx_pad_b), .rx_pad(rx_pad_b)
    );

    assign rx_pad_b = loop_b ? tx_pad_b : rx_drv_b;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt_a = 0;
    int rx_cnt_b = 0;
    logic [7:0] tx_exp_a [$];
    logic [9:0] rx_exp_a [$];
    logic [9:0] rx_exp_b [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (rst_l !== 1'b1) ab = 1'b1;
        end
    endtask

    // Write one byte into instance a (to_b=0) or b; returns on the negedge after the accepting edge.
    task automatic send(input bit to_b, input logic [7:0] d);
        int k;
        logic rdy;
        k = 0;
        @(negedge clk);
        rdy = to_b ? ifb.tx_ready : ifa.tx_ready;
        while (rdy !== 1'b1 && k < 40 * DIV) begin
            @(negedge clk);
            k++;
            rdy = to_b ? ifb.tx_ready : ifa.tx_ready;
        end
        if (rdy !== 1'b1) begin
            check("tx_ready_wait", {31'd0, rdy}, 32'd1);
        end else begin
            if (to_b) begin
                ifb.tx_data = d; ifb.tx_strobe = 1'b1;
            end else begin
                ifa.tx_data = d; ifa.tx_strobe = 1'b1;
                tx_exp_a.push_back(d);
            end
            @(negedge clk);
            ifa.tx_strobe = 1'b0;
            ifb.tx_strobe = 1'b0;
        end
    endtask

    task automatic put_bit(input bit to_b, input logic v);
        if (to_b) rx_drv_b = v;
        else      rx_pad_a = v;
        repeat (DIV) @(negedge clk);
    endtask

    // Bench-generated serial frame; a low stop bit can be followed by extra low bit times.
    task automatic drive_frame(input bit to_b, input logic [7:0] d, input int nbits,
                               input bit use_par, input logic par, input logic stop,
                               input int low_bits);
        put_bit(to_b, 1'b0);
        for (int i = 0; i < nbits; i++) put_bit(to_b, d[i]);
        if (use_par) put_bit(to_b, par);
        put_bit(to_b, stop);
        if (stop == 1'b0) begin
            repeat (low_bits) put_bit(to_b, 1'b0);
        end
        put_bit(to_b, 1'b1);
        put_bit(to_b, 1'b1);
    endtask

    // TX decoder for instance a: centre-samples each frame and pops the expected byte.
    initial begin : tx_mon
        bit ab;
        bit have_start;
        int gap;
        logic [7:0] b;
        logic st, stp;
        have_start = 1'b0;
        forever begin
            if (!have_start) begin
                @(negedge clk);
                while (!(rst_l === 1'b1 && tx_pad_a === 1'b0)) @(negedge clk);
            end
            have_start = 1'b0;
            ab = 1'b0;
            wait_neg(DIV / 2 - 1, ab);
            st = tx_pad_a;
            for (int i = 0; i < 8; i++) begin
                wait_neg(DIV, ab);
                b[i] = tx_pad_a;
            end
            wait_neg(DIV, ab);
            stp = tx_pad_a;
            if (!ab) begin
                if (tx_exp_a.size() == 0) begin
                    check("tx_unexpected_frame", tx_exp_a.size(), 32'd1);
                end else begin
                    check("tx_frame", {22'd0, stp, b, st}, {22'd0, 1'b1, tx_exp_a.pop_front(), 1'b0});
                    if (tx_exp_a.size() > 0) begin
                        gap = 0;
                        while (tx_pad_a !== 1'b0 && gap < 2 * DIV) begin
                            @(negedge clk);
                            gap++;
                        end
                        check("tx_gap_bounded", {31'd0, gap <= DIV / 2 + 2}, 32'd1);
                        have_start = (tx_pad_a === 1'b0);
                    end
                end
            end
        end
    end

    // RX result scoreboards for both instances.
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (rst_l === 1'b1 && ifa.rx_strobe === 1'b1) begin
                rx_cnt_a++;
                if (rx_exp_a.size() == 0) check("rx_a_unexpected", rx_exp_a.size(), 32'd1);
                else check("rx_a_word", {22'd0, ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_data},
                           {22'd0, rx_exp_a.pop_front()});
            end
            if (rst_l === 1'b1 && ifb.rx_strobe === 1'b1) begin
                rx_cnt_b++;
                if (rx_exp_b.size() == 0) check("rx_b_unexpected", rx_exp_b.size(), 32'd1);
                else check("rx_b_word", {22'd0, ifb.rx_frame_err, ifb.rx_parity_err, ifb.rx_data},
                           {22'd0, rx_exp_b.pop_front()});
            end
        end
    end

    initial begin : main
        logic [9:0] fr;
        int cnt0, idx, waited, acc4, lows;
        bit full_seen;
        rst_l = 1'b0; rx_pad_a = 1'b1; rx_drv_b = 1'b1; loop_b = 1'b0;
        ifa.tx_strobe = 1'b0; ifa.tx_data = 8'd0;
        ifb.tx_strobe = 1'b0; ifb.tx_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_tx_pad", {31'd0, tx_pad_a}, 32'd1);
        check("rst_tx_ready", {31'd0, ifa.tx_ready}, 32'd1);
        check("rst_rx_strobe", {31'd0, ifa.rx_strobe}, 32'd0);
        check("rst_rx_data", {24'd0, ifa.rx_data}, 32'd0);
        check("rst_rx_errs", {30'd0, ifa.rx_frame_err, ifa.rx_parity_err}, 32'd0);
        rst_l = 1'b1;
        repeat (4 * DIV) @(negedge clk);

        // 0x55: start bit at E+2, every bit exactly DIV clocks
        send(1'b0, 8'h55);
        check("t55_e0", {31'd0, tx_pad_a}, 32'd1);
        @(negedge clk);
        check("t55_e1", {31'd0, tx_pad_a}, 32'd1);
        @(negedge clk);
        fr = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check("t55_bit_first", {31'd0, tx_pad_a}, {31'd0, fr[k]});
            repeat (DIV - 1) @(negedge clk);
            check("t55_bit_last", {31'd0, tx_pad_a}, {31'd0, fr[k]});
            @(negedge clk);
        end
        repeat (DIV) @(negedge clk);

        // FIFO fill while a frame is in flight: 4 accepted, 5th waits for a pop
        send(1'b0, 8'h11);
        repeat (4) @(negedge clk);
        idx = 0; waited = 0; acc4 = 0; full_seen = 1'b0;
        ifa.tx_data = 8'h21; ifa.tx_strobe = 1'b1;
        while (idx < 5 && waited < 30 * DIV) begin
            if (ifa.tx_ready === 1'b1) begin
                tx_exp_a.push_back(ifa.tx_data);
                idx++;
            end
            @(negedge clk);
            waited++;
            if (idx == 4 && !full_seen) begin
                check("fifo_full_ready", {31'd0, ifa.tx_ready}, 32'd0);
                full_seen = 1'b1;
                acc4 = waited;
            end
            ifa.tx_data = 8'h21 + 8'(idx);
        end
        ifa.tx_strobe = 1'b0;
        check("fifo_fifth_accepted", idx, 32'd5);
        check("fifo_fifth_waited", {31'd0, (waited - acc4) > 4 * DIV}, 32'd1);
        repeat (66 * DIV) @(negedge clk);

        // RX glitch shorter than half a bit is ignored
        cnt0 = rx_cnt_a;
        rx_pad_a = 1'b0;
        repeat (DIV * 3 / 10) @(negedge clk);
        rx_pad_a = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_no_strobe", rx_cnt_a, cnt0);
        rx_exp_a.push_back({2'b00, 8'hA5});
        drive_frame(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 0);
        check("a5_one_strobe", rx_cnt_a, cnt0 + 1);

        // Framing error followed by a held-low line, then a clean byte
        cnt0 = rx_cnt_a;
        rx_exp_a.push_back({2'b10, 8'h3C});
        drive_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 3);
        check("break_one_strobe", rx_cnt_a, cnt0 + 1);
        check("ferr_held", {31'd0, ifa.rx_frame_err}, 32'd1);
        rx_exp_a.push_back({2'b00, 8'h5A});
        drive_frame(1'b0, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 0);
        check("ferr_cleared", {31'd0, ifa.rx_frame_err}, 32'd0);

        // 7E2 loopback: bit 7 dropped, parity bit 0 then 1
        loop_b = 1'b1;
        rx_exp_b.push_back({2'b00, 8'h03});
        send(1'b1, 8'h83);
        repeat (2 + 8 * DIV + DIV / 2) @(negedge clk);
        check("b_parity_bit0", {31'd0, tx_pad_b}, 32'd0);
        repeat (4 * DIV) @(negedge clk);
        check("b_strobe_once", rx_cnt_b, 32'd1);
        rx_exp_b.push_back({2'b00, 8'h07});
        send(1'b1, 8'h07);
        repeat (2 + 8 * DIV + DIV / 2) @(negedge clk);
        check("b_parity_bit1", {31'd0, tx_pad_b}, 32'd1);
        repeat (4 * DIV) @(negedge clk);
        check("b_strobe_twice", rx_cnt_b, 32'd2);

        // Bench-driven parity error on the 7E2 receiver, then a correct frame
        loop_b = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        rx_exp_b.push_back({2'b01, 8'h15});
        drive_frame(1'b1, 8'h15, 7, 1'b1, 1'b0, 1'b1, 0);
        rx_exp_b.push_back({2'b00, 8'h15});
        drive_frame(1'b1, 8'h15, 7, 1'b1, 1'b1, 1'b1, 0);
        check("b_strobe_four", rx_cnt_b, 32'd4);

        // Reset mid-frame with three bytes queued
        send(1'b0, 8'h81);
        send(1'b0, 8'h82);
        send(1'b0, 8'h83);
        send(1'b0, 8'h84);
        repeat (3 * DIV) @(negedge clk);
        rst_l = 1'b0;
        #1;
        check("mid_rst_tx_pad", {31'd0, tx_pad_a}, 32'd1);
        check("mid_rst_tx_ready", {31'd0, ifa.tx_ready}, 32'd1);
        check("mid_rst_rx_data", {24'd0, ifa.rx_data}, 32'd0);
        check("mid_rst_rx_data_b", {24'd0, ifb.rx_data}, 32'd0);
        check("mid_rst_errs", {30'd0, ifb.rx_frame_err, ifb.rx_parity_err}, 32'd0);
        tx_exp_a.delete();
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        lows = 0;
        repeat (45 * DIV) begin
            @(negedge clk);
            if (tx_pad_a !== 1'b1) lows++;
        end
        check("rst_nothing_sent", lows, 32'd0);

        check("tx_sb_drained", tx_exp_a.size(), 32'd0);
        check("rx_a_sb_drained", rx_exp_a.size(), 32'd0);
        check("rx_b_sb_drained", rx_exp_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
